// File: rtl/vga_timing_defs.sv
// vga_timing_defs -- default 1024x768@60 timing constants shared by the
// timing generator and its testbench.
//   VGA_H_* : horizontal active / front porch / sync / back porch / polarity
//   VGA_V_* : vertical   active / front porch / sync / back porch / polarity
//   VGA_H_DIM / VGA_V_DIM : MSB index of the horizontal / vertical counts
package vga_timing_defs;

    localparam int VGA_H_RES  = 1024;
    localparam int VGA_H_FP   = 24;
    localparam int VGA_H_SYNC = 136;
    localparam int VGA_H_BP   = 160;
    localparam bit VGA_H_POL  = 1'b0;

    localparam int VGA_V_RES  = 768;
    localparam int VGA_V_FP   = 3;
    localparam int VGA_V_SYNC = 6;
    localparam int VGA_V_BP   = 29;
    localparam bit VGA_V_POL  = 1'b0;

    localparam int VGA_H_DIM  = 11;
    localparam int VGA_V_DIM  = 10;

endpackage

// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg -- helper functions shared by the timing generator and
// its axis counters.
//   axis_total  : total counts of one axis (active + porches + sync)
//   count_fits  : whether a terminal count fits in a counter whose MSB is dim
package vga_timing_gen_pkg;

    function automatic int axis_total(input int res, input int fp,
                                      input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

    function automatic bit count_fits(input int last, input int dim);
        return (last >> (dim + 1)) == 0;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if -- video timing bundle between the timing generator
// (master) and a pixel pipeline consuming it (slave).
//   CE          : pixel-clock enable, driven by the consumer
//   HSYNC/VSYNC : sync levels
//   DISP_EN     : active-video flag
//   POS_X/POS_Y : current horizontal / vertical counts (blanking included)
//   LINE_START  : one-cycle pulse at horizontal count 0
//   FRAME_START : one-cycle pulse at count (0,0)
interface vga_timing_gen_if #(
    parameter int H_DIM = 11,
    parameter int V_DIM = 10
);

    logic         CE;
    logic         HSYNC;
    logic         VSYNC;
    logic         DISP_EN;
    logic [H_DIM:0] POS_X;
    logic [V_DIM:0] POS_Y;
    logic         LINE_START;
    logic         FRAME_START;

    modport master (
        input  CE,
        output HSYNC, VSYNC, DISP_EN, POS_X, POS_Y, LINE_START, FRAME_START
    );

    modport slave (
        output CE,
        input  HSYNC, VSYNC, DISP_EN, POS_X, POS_Y, LINE_START, FRAME_START
    );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter -- one wrapping video-timing axis counter with decode.
//   PIX_CLK : pixel clock, rising edge
//   RST     : asynchronous active-high reset, clears the count
//   inc     : advance the count by one on this edge
//   cnt     : current count, 0..TOTAL-1
//   wrap    : inc is high and the count is at TOTAL-1 (wraps on this edge)
//   active  : count lies in the active region (cnt < RES)
//   sync    : sync level for the current count (POL inside the pulse)
module vga_axis_counter
    import vga_timing_defs::*;
    import vga_timing_gen_pkg::*;
#(
    parameter int RES  = VGA_H_RES,
    parameter int FP   = VGA_H_FP,
    parameter int SYNC = VGA_H_SYNC,
    parameter int BP   = VGA_H_BP,
    parameter bit POL  = VGA_H_POL,
    parameter int DIM  = VGA_H_DIM
)(
    input  logic         PIX_CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [DIM:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam int TOTAL      = axis_total(RES, FP, SYNC, BP);
    localparam int LAST_I     = TOTAL - 1;
    localparam int SYNC_BEG_I = RES + FP;
    localparam int SYNC_END_I = RES + FP + SYNC - 1;

    localparam logic [DIM:0] LAST_C     = LAST_I[DIM:0];
    localparam logic [DIM:0] RES_C      = RES[DIM:0];
    localparam logic [DIM:0] SYNC_BEG_C = SYNC_BEG_I[DIM:0];
    localparam logic [DIM:0] SYNC_END_C = SYNC_END_I[DIM:0];
    localparam logic [DIM:0] ZERO_C     = {(DIM + 1){1'b0}};
    localparam logic [DIM:0] ONE_C      = {{DIM{1'b0}}, 1'b1};

    // A zero-width sync pulse or a count that overflows the port is a
    // configuration error that must stop elaboration.
    if (SYNC == 0) begin : g_bad_sync
        $error("vga_axis_counter: SYNC must be non-zero");
    end
    if (!count_fits(LAST_I, DIM)) begin : g_bad_dim
        $error("vga_axis_counter: TOTAL-1 does not fit in DIM+1 bits");
    end

    logic [DIM:0] cnt_r;
    logic         wrap_s;
    logic         active_s;
    logic         sync_s;

    // Count register: advance on inc, wrap to zero after the last count.
    always_ff @(posedge PIX_CLK or posedge RST) begin
        if (RST) begin
            cnt_r <= ZERO_C;
        end else if (inc) begin
            if (cnt_r == LAST_C) begin
                cnt_r <= ZERO_C;
            end else begin
                cnt_r <= cnt_r + ONE_C;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Decode of the current count: wrap strobe, active region, sync level.
    always_comb begin
        wrap_s   = 1'b0;
        active_s = 1'b0;
        sync_s   = ~POL;
        if (inc && (cnt_r == LAST_C)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
        if (cnt_r < RES_C) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end
        if ((cnt_r >= SYNC_BEG_C) && (cnt_r <= SYNC_END_C)) begin
            sync_s = POL;
        end else begin
            sync_s = ~POL;
        end
    end

    assign cnt    = cnt_r;
    assign wrap   = wrap_s;
    assign active = active_s;
    assign sync   = sync_s;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing generator.
// Two chained axis counters produce the (hc,vc) raster position; every output
// is registered from the pair that was current before each CE=1 edge.
//   PIX_CLK : pixel clock, rising edge
//   RST     : asynchronous active-high reset
//   vga     : timing bundle (CE in; HSYNC, VSYNC, DISP_EN, POS_X, POS_Y,
//             LINE_START, FRAME_START out)
module vga_timing_gen
    import vga_timing_defs::*;
#(
    parameter int H_RES  = VGA_H_RES,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_RES  = VGA_V_RES,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP,
    parameter bit H_POL  = VGA_H_POL,
    parameter bit V_POL  = VGA_V_POL,
    parameter int H_DIM  = VGA_H_DIM,
    parameter int V_DIM  = VGA_V_DIM
)(
    input  logic             PIX_CLK,
    input  logic             RST,
    vga_timing_gen_if.master vga
);

    localparam logic [H_DIM:0] H_ZERO_C = {(H_DIM + 1){1'b0}};
    localparam logic [V_DIM:0] V_ZERO_C = {(V_DIM + 1){1'b0}};

    logic [H_DIM:0] hc_s;
    logic [V_DIM:0] vc_s;
    logic           h_wrap_s;
    logic           h_active_s;
    logic           h_sync_s;
    logic           v_wrap_unused_s;
    logic           v_active_s;
    logic           v_sync_s;

    logic           hsync_r;
    logic           vsync_r;
    logic           disp_en_r;
    logic [H_DIM:0] pos_x_r;
    logic [V_DIM:0] pos_y_r;
    logic           line_start_r;
    logic           frame_start_r;

    vga_axis_counter #(
        .RES  (H_RES),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .POL  (H_POL),
        .DIM  (H_DIM)
    ) u_h_axis (
        .PIX_CLK (PIX_CLK),
        .RST     (RST),
        .inc     (vga.CE),
        .cnt     (hc_s),
        .wrap    (h_wrap_s),
        .active  (h_active_s),
        .sync    (h_sync_s)
    );

    // The vertical axis steps only on the edge where the line wraps, so
    // both counters return to zero together at the end of a frame.
    vga_axis_counter #(
        .RES  (V_RES),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .POL  (V_POL),
        .DIM  (V_DIM)
    ) u_v_axis (
        .PIX_CLK (PIX_CLK),
        .RST     (RST),
        .inc     (h_wrap_s),
        .cnt     (vc_s),
        .wrap    (v_wrap_unused_s),
        .active  (v_active_s),
        .sync    (v_sync_s)
    );

    // Output registers: capture the pre-edge position on CE=1; on CE=0 hold
    // levels and counts but drop the start pulses so they never repeat.
    always_ff @(posedge PIX_CLK or posedge RST) begin
        if (RST) begin
            hsync_r       <= ~H_POL;
            vsync_r       <= ~V_POL;
            disp_en_r     <= 1'b0;
            pos_x_r       <= H_ZERO_C;
            pos_y_r       <= V_ZERO_C;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (vga.CE) begin
            hsync_r       <= h_sync_s;
            vsync_r       <= v_sync_s;
            disp_en_r     <= h_active_s & v_active_s;
            pos_x_r       <= hc_s;
            pos_y_r       <= vc_s;
            line_start_r  <= (hc_s == H_ZERO_C);
            frame_start_r <= (hc_s == H_ZERO_C) && (vc_s == V_ZERO_C);
        end else begin
            hsync_r       <= hsync_r;
            vsync_r       <= vsync_r;
            disp_en_r     <= disp_en_r;
            pos_x_r       <= pos_x_r;
            pos_y_r       <= pos_y_r;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end
    end

    assign vga.HSYNC       = hsync_r;
    assign vga.VSYNC       = vsync_r;
    assign vga.DISP_EN     = disp_en_r;
    assign vga.POS_X       = pos_x_r;
    assign vga.POS_Y       = pos_y_r;
    assign vga.LINE_START  = line_start_r;
    assign vga.FRAME_START = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- self-checking bench for vga_timing_gen.
// A small 14x8 configuration is driven with fixed and random CE patterns and
// compared every cycle against a raster model indexed by the number of CE=1
// edges since reset; a default-timing instance is checked over two lines.
module tb_vga_timing_gen;
    import vga_timing_defs::*;

    localparam int S_H_RES = 8;
    localparam int S_H_FP = 2;
    localparam int S_H_SYNC = 3;
    localparam int S_H_BP = 1;
    localparam int S_V_RES = 4;
    localparam int S_V_FP = 1;
    localparam int S_V_SYNC = 2;
    localparam int S_V_BP = 1;
    localparam int S_HT = S_H_RES + S_H_FP + S_H_SYNC + S_H_BP;
    localparam int S_VT = S_V_RES + S_V_FP + S_V_SYNC + S_V_BP;

    localparam int D_HT = VGA_H_RES + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    logic PIX_CLK = 1'b0;
    logic RST = 1'b1;

    vga_timing_gen_if #(.H_DIM(3), .V_DIM(2)) s_if ();
    vga_timing_gen_if d_if ();

    vga_timing_gen #(
        .H_RES(S_H_RES), .H_FP(S_H_FP), .H_SYNC(S_H_SYNC), .H_BP(S_H_BP),
        .V_RES(S_V_RES), .V_FP(S_V_FP), .V_SYNC(S_V_SYNC), .V_BP(S_V_BP),
        .H_POL(1'b0), .V_POL(1'b0), .H_DIM(3), .V_DIM(2)
    ) u_small (
        .PIX_CLK (PIX_CLK),
        .RST     (RST),
        .vga     (s_if.master)
    );

    vga_timing_gen u_dflt (
        .PIX_CLK (PIX_CLK),
        .RST     (RST),
        .vga     (d_if.master)
    );

    always #5 PIX_CLK = ~PIX_CLK;

    int vectors = 0;
    int miscompares = 0;

    // Expected outputs of the small instance.
    int n = 0;
    int e_x, e_y, e_de, e_hs, e_vs, e_ls, e_fs;
    int last_ls = -1;
    int last_fs = -1;

    task automatic check_val(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        e_x = 0; e_y = 0; e_de = 0; e_hs = 1; e_vs = 1; e_ls = 0; e_fs = 0;
        last_ls = -1;
        last_fs = -1;
    endtask

    // Raster model: the k-th CE=1 edge after reset shows position k mod frame.
    task automatic model_edge(input logic ce);
        int x, y;
        if (RST) begin
            model_reset();
        end else if (ce) begin
            x = n % S_HT;
            y = (n / S_HT) % S_VT;
            e_x = x;
            e_y = y;
            e_de = (x < S_H_RES && y < S_V_RES) ? 1 : 0;
            e_hs = (x >= S_H_RES + S_H_FP && x < S_H_RES + S_H_FP + S_H_SYNC) ? 0 : 1;
            e_vs = (y >= S_V_RES + S_V_FP && y < S_V_RES + S_V_FP + S_V_SYNC) ? 0 : 1;
            e_ls = (x == 0) ? 1 : 0;
            e_fs = (x == 0 && y == 0) ? 1 : 0;
            n++;
        end else begin
            e_ls = 0;
            e_fs = 0;
        end
    endtask

    task automatic check_small();
        check_val("pos_x", int'(s_if.POS_X), e_x);
        check_val("pos_y", int'(s_if.POS_Y), e_y);
        check_val("disp_en", int'(s_if.DISP_EN), e_de);
        check_val("hsync", int'(s_if.HSYNC), e_hs);
        check_val("vsync", int'(s_if.VSYNC), e_vs);
        check_val("line_start", int'(s_if.LINE_START), e_ls);
        check_val("frame_start", int'(s_if.FRAME_START), e_fs);
    endtask

    // One clock with the given CE: model update at the edge, check on negedge.
    task automatic step(input logic ce);
        s_if.CE = ce;
        @(posedge PIX_CLK);
        model_edge(ce);
        @(negedge PIX_CLK);
        check_small();
        if (s_if.LINE_START === 1'b1) begin
            if (last_ls >= 0) check_val("ls_period", n - last_ls, S_HT);
            last_ls = n;
        end
        if (s_if.FRAME_START === 1'b1) begin
            if (last_fs >= 0) check_val("fs_period", n - last_fs, S_HT * S_VT);
            last_fs = n;
        end
    endtask

    initial begin
        int de_cnt, hs_cnt, vs_cnt, guard, x, y;
        s_if.CE = 1'b1;
        d_if.CE = 1'b0;
        model_reset();

        // Reset held with CE high: outputs stay at reset values.
        @(negedge PIX_CLK);
        check_small();
        step(1'b1);
        step(1'b1);

        // Release and scan two full frames with CE held high.
        RST = 1'b0;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < 2 * S_HT * S_VT; i++) begin
            step(1'b1);
            if (i < S_HT * S_VT) begin
                if (s_if.DISP_EN === 1'b1) de_cnt++;
                if (s_if.HSYNC === 1'b0) hs_cnt++;
                if (s_if.VSYNC === 1'b0) vs_cnt++;
            end
        end
        check_val("de_per_frame", de_cnt, S_H_RES * S_V_RES);
        check_val("hs_low_per_frame", hs_cnt, S_H_SYNC * S_VT);
        check_val("vs_low_per_frame", vs_cnt, S_V_SYNC * S_HT);

        // CE pattern 1,0,0,1 repeated.
        for (int i = 0; i < 160; i++) begin
            step((i % 4 == 0 || i % 4 == 3) ? 1'b1 : 1'b0);
        end

        // Random CE.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)));
        end

        // Advance to position (9,6), then reset asynchronously mid-cycle.
        guard = 0;
        while (!(e_x == 9 && e_y == 6) && guard < 300) begin
            step(1'b1);
            guard++;
        end
        check_val("reach_9_6", (e_x == 9 && e_y == 6) ? 1 : 0, 1);
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_small();
        step(1'b1);
        RST = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1);
        end

        // Default timing: reset, then two lines plus a little with CE high.
        s_if.CE = 1'b0;
        RST = 1'b1;
        @(negedge PIX_CLK);
        check_val("dflt_rst_hsync", int'(d_if.HSYNC), 1);
        check_val("dflt_rst_de", int'(d_if.DISP_EN), 0);
        RST = 1'b0;
        d_if.CE = 1'b1;
        de_cnt = 0;
        hs_cnt = 0;
        for (int k = 0; k < 2 * D_HT + 4; k++) begin
            @(posedge PIX_CLK);
            @(negedge PIX_CLK);
            x = k % D_HT;
            y = k / D_HT;
            check_val("d_pos_x", int'(d_if.POS_X), x);
            check_val("d_pos_y", int'(d_if.POS_Y), y);
            check_val("d_line_start", int'(d_if.LINE_START), (x == 0) ? 1 : 0);
            check_val("d_frame_start", int'(d_if.FRAME_START), (k == 0) ? 1 : 0);
            check_val("d_disp_en", int'(d_if.DISP_EN),
                      (x < VGA_H_RES && y < VGA_V_RES) ? 1 : 0);
            if (k < D_HT) begin
                if (d_if.DISP_EN === 1'b1) de_cnt++;
                if (d_if.HSYNC === 1'b0) hs_cnt++;
            end
        end
        check_val("d_de_per_line", de_cnt, VGA_H_RES);
        check_val("d_hs_low_per_line", hs_cnt, VGA_H_SYNC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
